// File: rtl/nz_sched_ctrl.sv
// nz_sched_ctrl
// Sequencer for the 6-way non-zero address generator feeding a PE row.
// Takes one sparsity bitmap per feature sub-vector, hands it to the
// generator, and keeps re-feeding the generator's residual bitmap until
// every set bit has been extracted. Each pass becomes one output beat.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   in_valid/ready   bitmap handshake (ready only in IDLE)
//   in_bitmap        sparsity bitmap
//   flush            synchronous abort of the current vector
//   gen_data_bus     registered bitmap driven to the generator
//   gen_addr_bus     generator addresses, MSB field = first extracted
//   gen_data_out     generator residual bitmap
//   gen_done         generator residual-empty flag (not used for sequencing)
//   out_valid/ready  beat handshake
//   out_addr_bus     beat addresses, unqualified fields forced to 0
//   out_lane_valid   lane k qualifies address field k
//   out_last         final beat of the vector
//   beat_count       beats emitted for the current vector
//   busy             state is not IDLE
//
// state | meaning
// IDLE  | waiting for a bitmap
// ISSUE | generator samples gen_data_bus; lane count and last flag decided
// WAIT  | generator outputs valid; beat captured
// OUT   | beat presented until out_ready
module nz_sched_ctrl #(
   parameter int DIM        = 6,
   parameter int SPAD_WIDTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 7
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SPAD_WIDTH-1:0]      in_bitmap,
   input  logic                       flush,
   output logic [SPAD_WIDTH-1:0]      gen_data_bus,
   input  logic [ADDR_WIDTH*DIM-1:0]  gen_addr_bus,
   input  logic [SPAD_WIDTH-1:0]      gen_data_out,
   input  logic                       gen_done,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_WIDTH*DIM-1:0]  out_addr_bus,
   output logic [DIM-1:0]             out_lane_valid,
   output logic                       out_last,
   output logic [CNT_WIDTH-1:0]       beat_count,
   output logic                       busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [SPAD_WIDTH-1:0]       r_remaining;
   logic [SPAD_WIDTH-1:0]       r_next_remaining;
   logic [SPAD_WIDTH-1:0]       r_gen_data;
   logic [CNT_WIDTH-1:0]        r_n;
   logic                        r_last;
   logic [CNT_WIDTH-1:0]        r_beat_count;
   logic [ADDR_WIDTH*DIM-1:0]   r_addr;
   logic [DIM-1:0]              r_lane_valid;
   logic                        r_out_last;

   logic [CNT_WIDTH-1:0]        w_popcount;
   logic [CNT_WIDTH-1:0]        w_n;
   logic                        w_last;
   logic [DIM-1:0]              w_lane_mask;
   logic [ADDR_WIDTH*DIM-1:0]   w_addr_masked;
   logic                        w_accept;
   logic                        w_abort;
   logic                        w_unused;

   // Residual-empty is redundant with the popcount-based last decision.
   assign w_unused = gen_done;

   assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
   assign w_abort  = (r_state != S_IDLE) && flush;

   always_comb begin
      w_popcount = '0;
      for (int i = 0; i < SPAD_WIDTH; i++) begin
         w_popcount = w_popcount + CNT_WIDTH'(r_remaining[i]);
      end
      w_last = (w_popcount <= CNT_WIDTH'(DIM));
      w_n    = w_last ? w_popcount : CNT_WIDTH'(DIM);
   end

   // Lanes fill from the MSB field down, matching the generator's order.
   always_comb begin
      w_lane_mask   = '0;
      w_addr_masked = '0;
      for (int k = 0; k < DIM; k++) begin
         w_lane_mask[k] = (CNT_WIDTH'(k) >= (CNT_WIDTH'(DIM) - r_n));
         if (w_lane_mask[k]) begin
            w_addr_masked[k*ADDR_WIDTH +: ADDR_WIDTH] = gen_addr_bus[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (w_accept) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  w_state_nxt = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = r_out_last ? S_IDLE : S_ISSUE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_remaining      <= '0;
         r_next_remaining <= '0;
         r_gen_data       <= '0;
         r_n              <= '0;
         r_last           <= 1'b0;
         r_beat_count     <= '0;
         r_addr           <= '0;
         r_lane_valid     <= '0;
         r_out_last       <= 1'b0;
      end else if (w_abort) begin
         r_gen_data   <= '0;
         r_beat_count <= '0;
         r_addr       <= '0;
         r_lane_valid <= '0;
         r_out_last   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_remaining  <= in_bitmap;
                  r_gen_data   <= in_bitmap;
                  r_beat_count <= '0;
               end
            end
            S_ISSUE: begin
               r_n    <= w_n;
               r_last <= w_last;
            end
            S_WAIT: begin
               r_addr           <= w_addr_masked;
               r_lane_valid     <= w_lane_mask;
               r_out_last       <= r_last;
               r_beat_count     <= r_beat_count + 1'b1;
               r_next_remaining <= gen_data_out;
            end
            S_OUT: begin
               if (out_ready) begin
                  if (r_out_last) begin
                     r_gen_data <= '0;
                  end else begin
                     r_remaining <= r_next_remaining;
                     r_gen_data  <= r_next_remaining;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign gen_data_bus   = r_gen_data;
   assign out_addr_bus   = r_addr;
   assign out_lane_valid = r_lane_valid;
   assign out_last       = r_out_last;
   assign beat_count     = r_beat_count;

endmodule

// File: tb/tb_nz_sched_ctrl.sv
// Testbench for nz_sched_ctrl. Includes a behavioural model of the
// registered 6-way non-zero address generator; unused address fields are
// filled with all-ones so that missing zero-forcing shows up.
module tb_nz_sched_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_bitmap;
   logic         flush;
   logic [63:0]  gen_data_bus;
   logic [35:0]  gen_addr_bus;
   logic [63:0]  gen_data_out;
   logic         gen_done;
   logic         out_valid;
   logic         out_ready;
   logic [35:0]  out_addr_bus;
   logic [5:0]   out_lane_valid;
   logic         out_last;
   logic [6:0]   beat_count;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] first_f5;

   nz_sched_ctrl #(.DIM(6), .SPAD_WIDTH(64), .ADDR_WIDTH(6), .CNT_WIDTH(7)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_bitmap(in_bitmap), .flush(flush), .gen_data_bus(gen_data_bus),
      .gen_addr_bus(gen_addr_bus), .gen_data_out(gen_data_out), .gen_done(gen_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr_bus(out_addr_bus),
      .out_lane_valid(out_lane_valid), .out_last(out_last),
      .beat_count(beat_count), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [35:0] f_gen_addr(input logic [63:0] d);
      logic [35:0] a;
      int j;
      a = '1;
      j = 0;
      for (int i = 0; i < 64; i++) begin
         if (d[i] && j < 6) begin
            a[(5-j)*6 +: 6] = 6'(i);
            j++;
         end
      end
      return a;
   endfunction

   function automatic logic [63:0] f_gen_res(input logic [63:0] d);
      logic [63:0] r;
      int j;
      r = d;
      j = 0;
      for (int i = 0; i < 64; i++) begin
         if (d[i] && j < 6) begin
            r[i] = 1'b0;
            j++;
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      gen_addr_bus <= f_gen_addr(gen_data_bus);
      gen_data_out <= f_gen_res(gen_data_bus);
      gen_done     <= (f_gen_res(gen_data_bus) == 64'h0);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vector(input logic [63:0] bm, input int exp_beats,
                             input logic [5:0] exp_last_lanes, input int hold_beat);
      logic [63:0] rem;
      logic [5:0]  el;
      logic [5:0]  a;
      logic [5:0]  last_lanes;
      logic [50:0] snap;
      logic        ok;
      logic        done_flag;
      int beat, wcnt, pc, n;
      out_ready = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      in_bitmap = bm;
      in_valid  = 1'b1;
      tick;
      in_valid  = 1'b0;
      chk("gen_bus_load", gen_data_bus, bm);
      chk("in_ready_busy", in_ready, 0);
      rem = bm;
      beat = 0;
      done_flag = 1'b0;
      last_lanes = '0;
      while (!done_flag) begin
         wcnt = 0;
         while (!out_valid && wcnt < 20) begin
            tick;
            wcnt++;
         end
         if (!out_valid) begin
            chk("beat_timeout", 0, 1);
            return;
         end
         beat++;
         chk("beat_latency", wcnt, 2);
         pc = $countones(rem);
         n  = (pc > 6) ? 6 : pc;
         el = '0;
         for (int k = 0; k < 6; k++) if (k >= 6 - n) el[k] = 1'b1;
         chk("lane_valid", out_lane_valid, el);
         chk("out_last", out_last, (pc <= 6) ? 1 : 0);
         chk("beat_count", beat_count, beat);
         chk("in_ready_out", in_ready, 0);
         ok = 1'b1;
         for (int k = 0; k < 6; k++) begin
            a = out_addr_bus[k*6 +: 6];
            if (el[k]) begin
               if (!rem[a]) ok = 1'b0;
               rem[a] = 1'b0;
            end else if (a != 6'd0) begin
               ok = 1'b0;
            end
         end
         chk("addr_set", ok, 1);
         if (beat == 1) first_f5 = out_addr_bus[35:30];
         if (beat == hold_beat) begin
            out_ready = 1'b0;
            snap = {out_valid, out_addr_bus, out_lane_valid, out_last, beat_count};
            repeat (5) begin
               tick;
               chk("hold_stable", {out_valid, out_addr_bus, out_lane_valid, out_last, beat_count}, snap);
            end
            out_ready = 1'b1;
         end
         done_flag  = out_last;
         last_lanes = out_lane_valid;
         tick;
         if (beat >= 16) done_flag = 1'b1;
      end
      chk("beat_total", beat, exp_beats);
      chk("last_lanes", last_lanes, exp_last_lanes);
      chk("all_addrs_once", rem, 64'h0);
      chk("in_ready_after", in_ready, 1);
      chk("busy_after", busy, 0);
   endtask

   task automatic flush_test;
      int wcnt;
      logic saw;
      in_bitmap = '1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick;
      in_valid  = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         wcnt = 0;
         while (!out_valid && wcnt < 20) begin
            tick;
            wcnt++;
         end
         if (!out_valid) begin
            chk("flush_timeout", 0, 1);
            return;
         end
         if (b < 4) begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
         end
      end
      chk("flush_pre_count", beat_count, 4);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_beat_count", beat_count, 0);
      chk("flush_gen_bus", gen_data_bus, 0);
      chk("flush_busy", busy, 0);
      chk("flush_outs", {out_addr_bus, out_lane_valid, out_last}, 0);
      out_ready = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         tick;
         if (out_valid) saw = 1'b1;
      end
      chk("flush_no_more_beats", saw, 0);
   endtask

   task automatic reset_mid_wait_test;
      int wcnt;
      in_bitmap = '1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick;
      in_valid  = 1'b0;
      wcnt = 0;
      while (!out_valid && wcnt < 20) begin
         tick;
         wcnt++;
      end
      chk("rst_first_beat", out_valid, 1);
      tick;
      tick;
      chk("rst_busy_in_wait", busy, 1);
      reset = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_beat_count", beat_count, 0);
      chk("rst_gen_bus", gen_data_bus, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {out_addr_bus, out_lane_valid, out_last}, 0);
      reset = 1'b0;
      tick;
      chk("rst_in_ready", in_ready, 1);
   endtask

   typedef struct {
      logic [63:0] bm;
      int          beats;
      logic [5:0]  last_lanes;
      int          hold_beat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{64'h1,                    1,  6'b100000, 0};
      vecs[1] = '{64'h3F,                   1,  6'b111111, 0};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  11, 6'b111100, 0};
      vecs[3] = '{64'h0,                    1,  6'b000000, 0};
      vecs[4] = '{64'h8000_0000_0000_0FFF,  3,  6'b100000, 1};
      vecs[5] = '{64'h8000_0000_0000_007F,  2,  6'b110000, 0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_bitmap = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_gen_bus", gen_data_bus, 0);
      chk("reset_beat_count", beat_count, 0);
      chk("reset_outs", {out_addr_bus, out_lane_valid, out_last}, 0);
      chk("reset_in_ready", in_ready, 1);
      reset = 1'b0;
      tick;

      in_bitmap = 64'hFF;
      in_valid  = 1'b1;
      flush     = 1'b1;
      chk("idle_flush_ready", in_ready, 1);
      tick;
      in_valid  = 1'b0;
      flush     = 1'b0;
      chk("idle_flush_no_accept", busy, 0);
      chk("idle_flush_gen_bus", gen_data_bus, 0);

      for (int i = 0; i < 6; i++) begin
         run_vector(vecs[i].bm, vecs[i].beats, vecs[i].last_lanes, vecs[i].hold_beat);
         if (i == 0) chk("bit0_field5", first_f5, 0);
      end

      flush_test;
      reset_mid_wait_test;
      run_vector(64'h2, 1, 6'b100000, 0);
      chk("bit1_field5", first_f5, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
